// File: rtl/instr_fetch.sv
// Instruction fetch front end: credit-limited request issue, in-order response
// tracking with redirect squashing, and a 2-entry buffer toward the decoder.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc
);
    localparam int DEPTH = 2;

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      inf_addr_q [DEPTH];
    logic [31:0]      inf_addr_d [DEPTH];
    logic             inf_head_q, inf_head_d;
    logic [1:0]       inf_cnt_q, inf_cnt_d;
    logic [31:0]      buf_word_q [DEPTH];
    logic [31:0]      buf_word_d [DEPTH];
    logic [31:0]      buf_addr_q [DEPTH];
    logic [31:0]      buf_addr_d [DEPTH];
    logic             buf_head_q, buf_head_d;
    logic [1:0]       buf_cnt_q, buf_cnt_d;
    logic [1:0]       drop_cnt_q, drop_cnt_d;

    logic             req_fire, rsp_fire, rsp_keep, dec_pop;
    logic             inf_tail, buf_tail;
    logic [2:0]       occupancy;
    logic [DEPTH-1:0] inf_we, buf_we;

    // Outstanding requests count against buffer space so a returning word always has a slot.
    always_comb begin
        occupancy      = {1'b0, inf_cnt_q} + {1'b0, buf_cnt_q};
        imem_req_valid = !rst && !redirect_valid && (occupancy < 3'd2);
        imem_req_addr  = pc_q;
        instr_valid    = (buf_cnt_q != 2'd0);
        instruction    = buf_word_q[buf_head_q];
        instr_pc       = buf_addr_q[buf_head_q];

        req_fire = imem_req_valid && imem_req_ready;
        rsp_fire = imem_rsp_valid && (inf_cnt_q != 2'd0);
        rsp_keep = rsp_fire && (drop_cnt_q == 2'd0) && !redirect_valid;
        dec_pop  = instr_valid && instr_ready;
        inf_tail = inf_head_q ^ inf_cnt_q[0];
        buf_tail = buf_head_q ^ buf_cnt_q[0];
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign inf_we[gi]     = req_fire && (inf_tail == 1'(gi));
            assign inf_addr_d[gi] = inf_we[gi] ? pc_q : inf_addr_q[gi];
            assign buf_we[gi]     = rsp_keep && (buf_tail == 1'(gi));
            assign buf_word_d[gi] = buf_we[gi] ? imem_rsp_data : buf_word_q[gi];
            assign buf_addr_d[gi] = buf_we[gi] ? inf_addr_q[inf_head_q] : buf_addr_q[gi];
        end
    endgenerate

    always_comb begin
        pc_d       = pc_q;
        inf_head_d = inf_head_q ^ rsp_fire;
        inf_cnt_d  = inf_cnt_q + {1'b0, req_fire} - {1'b0, rsp_fire};
        buf_head_d = buf_head_q ^ dec_pop;
        buf_cnt_d  = buf_cnt_q + {1'b0, rsp_keep} - {1'b0, dec_pop};
        drop_cnt_d = drop_cnt_q;

        if (req_fire) begin
            pc_d = pc_q + 32'd4;
        end
        if (redirect_valid) begin
            // Every request still outstanding after this cycle belongs to the old path.
            pc_d       = redirect_pc;
            buf_cnt_d  = 2'd0;
            drop_cnt_d = inf_cnt_q - {1'b0, rsp_fire};
        end else if (rsp_fire && (drop_cnt_q != 2'd0)) begin
            drop_cnt_d = drop_cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            inf_head_q <= 1'b0;
            inf_cnt_q  <= 2'd0;
            buf_head_q <= 1'b0;
            buf_cnt_q  <= 2'd0;
            drop_cnt_q <= 2'd0;
            for (int i = 0; i < DEPTH; i++) begin
                inf_addr_q[i] <= '0;
                buf_word_q[i] <= '0;
                buf_addr_q[i] <= '0;
            end
        end else begin
            pc_q       <= pc_d;
            inf_head_q <= inf_head_d;
            inf_cnt_q  <= inf_cnt_d;
            buf_head_q <= buf_head_d;
            buf_cnt_q  <= buf_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                inf_addr_q[i] <= inf_addr_d[i];
                buf_word_q[i] <= buf_word_d[i];
                buf_addr_q[i] <= buf_addr_d[i];
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, hand-written redirect/reset sequences,
// and random traffic checked against a queue-based fetch model and memory model.
module tb_instr_fetch;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instruction;
    logic [31:0] instr_pc;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .instr_pc(instr_pc)
    );

    typedef struct { logic [31:0] addr; logic [31:0] data; } ent_t;
    typedef struct { logic [31:0] addr; bit keep; } inf_t;
    typedef struct { logic [31:0] addr; int cyc; } mreq_t;
    typedef struct {
        bit          rst_before;
        bit          rr;
        bit          ir;
        bit          e_rv;
        logic [31:0] e_addr;
        bit          e_iv;
        logic [31:0] e_pc;
    } vec_t;

    ent_t        bq[$];   // model: buffered instructions, oldest first
    inf_t        iq[$];   // model: outstanding requests, keep=0 once squashed
    mreq_t       mq[$];   // memory: accepted requests awaiting a response
    logic [31:0] dq[$];   // instr_pc of every instruction handed to the decoder
    vec_t        vt[$];
    logic [31:0] m_pc;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    bit          const_data = 1'b1;
    int          mem_lat = 1;
    int          rsp_pct = 100;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (const_data) return 32'h2308_8800;
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, then advance the model.
    task automatic step(input bit rr, input bit ir, input bit rv, input logic [31:0] rp);
        bit          rsp_now, exp_rv, accept;
        logic [31:0] old_pc;
        inf_t        t;
        @(negedge clk);
        imem_req_ready = rr;
        instr_ready    = ir;
        redirect_valid = rv;
        redirect_pc    = rp;
        rsp_now = (mq.size() > 0) && (cyc >= mq[0].cyc + mem_lat) &&
                  ($urandom_range(99) < rsp_pct);
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = rsp_now ? mem_word(mq[0].addr) : $urandom();
        #1;
        exp_rv = !rv && ((iq.size() + bq.size()) < 2);
        check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        check("req_addr", imem_req_addr, m_pc);
        check("instr_valid", 32'(instr_valid), 32'(bq.size() > 0));
        if (bq.size() > 0) begin
            check("instruction", instruction, bq[0].data);
            check("instr_pc", instr_pc, bq[0].addr);
        end
        accept = exp_rv && rr;
        old_pc = m_pc;
        if (bq.size() > 0 && ir) begin
            dq.push_back(bq[0].addr);
            void'(bq.pop_front());
        end
        if (rsp_now && iq.size() > 0) begin
            t = iq.pop_front();
            if (t.keep && !rv) bq.push_back('{t.addr, imem_rsp_data});
        end
        if (rv) begin
            bq.delete();
            foreach (iq[i]) iq[i].keep = 1'b0;
            m_pc = rp;
        end
        if (accept) begin
            iq.push_back('{old_pc, 1'b1});
            m_pc = old_pc + 32'd4;
        end
        if (rsp_now) void'(mq.pop_front());
        if (accept) mq.push_back('{old_pc, cyc});
        cyc++;
        $display("cyc %0d rr=%0d ir=%0d rv=%0d rsp=%0d req_valid=%0d addr=%h iv=%0d pc=%h",
                 cyc, rr, ir, rv, rsp_now, imem_req_valid, imem_req_addr, instr_valid, instr_pc);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        check({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_instruction"}, instruction, 32'd0);
        check({tag, "_instr_pc"}, instr_pc, 32'd0);
        check({tag, "_req_addr"}, imem_req_addr, RST_PC);
    endtask

    // Asynchronous reset pulse; optionally lets the memory return stale words meanwhile.
    task automatic do_reset(input int ncyc, input bit stale);
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_async");
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            redirect_valid = 1'b0;
            imem_req_ready = 1'b1;
            instr_ready    = 1'b1;
            imem_rsp_valid = stale ? 1'b1 : 1'b0;
            imem_rsp_data  = $urandom();
            #1 check_reset_outputs("rst_hold");
        end
        @(posedge clk);
        #1 rst = 1'b0;
        imem_rsp_valid = 1'b0;
        bq.delete(); iq.delete(); mq.delete(); dq.delete();
        m_pc = RST_PC;
    endtask

    task automatic wait_deliver(input string name, input logic [31:0] exp_pc);
        for (int i = 0; i < 30 && dq.size() == 0; i++) step(1'b1, 1'b1, 1'b0, 32'd0);
        if (dq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: no instruction delivered within 30 cycles, expected pc %h", name, exp_pc);
        end else begin
            check(name, dq[0], exp_pc);
        end
    endtask

    initial begin
        logic [31:0] tmp, rp;
        // Directed vectors: 1-cycle memory, steady streaming then decoder stall.
        vt.push_back('{1, 1, 1, 1, 32'h00, 0, 32'h0});
        vt.push_back('{0, 1, 1, 1, 32'h04, 0, 32'h0});
        vt.push_back('{0, 1, 1, 0, 32'h08, 1, 32'h0});
        vt.push_back('{0, 1, 1, 1, 32'h08, 1, 32'h4});
        vt.push_back('{0, 1, 1, 1, 32'h0C, 0, 32'h0});
        vt.push_back('{0, 1, 1, 0, 32'h10, 1, 32'h8});
        vt.push_back('{0, 1, 1, 1, 32'h10, 1, 32'hC});
        vt.push_back('{1, 1, 0, 1, 32'h00, 0, 32'h0});
        vt.push_back('{0, 1, 0, 1, 32'h04, 0, 32'h0});
        vt.push_back('{0, 1, 0, 0, 32'h08, 1, 32'h0});
        vt.push_back('{0, 1, 0, 0, 32'h08, 1, 32'h0});
        vt.push_back('{0, 1, 0, 0, 32'h08, 1, 32'h0});
        vt.push_back('{0, 1, 1, 0, 32'h08, 1, 32'h0});
        vt.push_back('{0, 1, 1, 1, 32'h08, 1, 32'h4});
        vt.push_back('{0, 1, 1, 1, 32'h0C, 0, 32'h0});
        vt.push_back('{0, 1, 1, 0, 32'h10, 1, 32'h8});

        m_pc = RST_PC;
        foreach (vt[i]) begin
            if (vt[i].rst_before) begin
                const_data = 1'b1; mem_lat = 1; rsp_pct = 100;
                do_reset(2, 1'b0);
            end
            step(vt[i].rr, vt[i].ir, 1'b0, 32'd0);
            check($sformatf("tbl%0d_req_valid", i), 32'(imem_req_valid), 32'(vt[i].e_rv));
            check($sformatf("tbl%0d_req_addr", i), imem_req_addr, vt[i].e_addr);
            check($sformatf("tbl%0d_instr_valid", i), 32'(instr_valid), 32'(vt[i].e_iv));
            if (vt[i].e_iv) check($sformatf("tbl%0d_instr_pc", i), instr_pc, vt[i].e_pc);
        end

        // Redirect with two requests outstanding: both words must be squashed.
        const_data = 1'b0; mem_lat = 3; rsp_pct = 100;
        do_reset(1, 1'b0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 1, 32'h100);
        @(posedge clk); #1 check("redir2_flush_iv", 32'(instr_valid), 32'd0);
        dq.delete();
        wait_deliver("redir2_first_pc", 32'h100);

        // Redirect in the same cycle as a response (and, for latency 1, a decoder pop).
        for (int lat = 1; lat <= 2; lat++) begin
            mem_lat = lat;
            do_reset(1, 1'b0);
            step(1, 1, 0, 0);
            step(1, 1, 0, 0);
            rp = 32'h200 + 32'(lat) * 32'h100;
            step(1, 1, 1, rp);
            if (lat == 1) check("redir_rsp_pop_delivered", dq.size() > 0 ? dq[0] : 32'hFFFF_FFFF, 32'h0);
            dq.delete();
            wait_deliver($sformatf("redir_rsp_lat%0d_pc", lat), rp);
        end

        // Address wrap at the top of the address space.
        mem_lat = 1;
        do_reset(1, 1'b0);
        step(1, 1, 1, 32'hFFFF_FFFC);
        step(1, 1, 0, 0);
        @(posedge clk); #1 check("wrap_next_addr", imem_req_addr, 32'h0000_0000);
        dq.delete();
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0);
        check("wrap_deliv0", dq.size() > 0 ? dq[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        check("wrap_deliv1", dq.size() > 1 ? dq[1] : 32'hDEAD_BEEF, 32'h0000_0000);

        // Reset pulse with two requests in flight; stale responses arrive during reset.
        mem_lat = 3;
        do_reset(1, 1'b0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        do_reset(3, 1'b1);
        step(1, 1, 0, 0);
        check("post_rst_first_req", imem_req_addr, RST_PC);
        check("post_rst_first_valid", 32'(imem_req_valid), 32'd1);
        wait_deliver("post_rst_first_pc", RST_PC);

        // Random traffic against the model.
        for (int blk = 0; blk < 3; blk++) begin
            mem_lat = 1 + blk;
            rsp_pct = 70;
            do_reset(2, 1'b1);
            for (int i = 0; i < 1000; i++) begin
                tmp = $urandom();
                rp  = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : {tmp[29:0], 2'b00};
                step($urandom_range(99) < 75, $urandom_range(99) < 70,
                     $urandom_range(99) < 4, rp);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
